// File: rtl/memarbiter.sv
// -----------------------------------------------------------------------------
// memarbiter
//
// Arbitrates three requesters (write buffer, data-cache fill, instruction-cache
// fill) onto a single external memory port. One transaction is in flight at a
// time. The write buffer always wins so that reads never overtake buffered
// writes. Data-cache beats instruction-cache, unless round-robin is enabled.
//
// Optional feature macro: MEMARB_ROUND_ROBIN_EN
//   When defined, simultaneous dreq/ireq conflicts alternate between the two
//   ports. The pointer moves to the other port after every dack/iack.
//   When undefined, dreq always beats ireq and no pointer state exists.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   wbreq/wbadr/wbdata/wbbyteen, wback    write-buffer request and ack pulse
//   dreq/dadr, dack/drdata                data-cache read request, ack, data
//   ireq/iadr, iack/irdata                instr-cache read request, ack, data
//   memadr/memwdata/membyteen/memrwb/memen  external memory request (registered)
//   memrdata/memdone                      memory read data and completion
// -----------------------------------------------------------------------------
module memarbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbreq,
    input  logic [29:0] wbadr,
    input  logic [31:0] wbdata,
    input  logic [3:0]  wbbyteen,
    output logic        wback,
    input  logic        dreq,
    input  logic [29:0] dadr,
    output logic        dack,
    output logic [31:0] drdata,
    input  logic        ireq,
    input  logic [29:0] iadr,
    output logic        iack,
    output logic [31:0] irdata,
    output logic [29:0] memadr,
    output logic [31:0] memwdata,
    output logic [3:0]  membyteen,
    output logic        memrwb,
    output logic        memen,
    input  logic [31:0] memrdata,
    input  logic        memdone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_D    = 2'd2,
        SRC_I    = 2'd3
    } src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    src_t        pick_s;
    logic        prefer_i_s;
    logic [29:0] memadr_q, memadr_d;
    logic [31:0] memwdata_q, memwdata_d;
    logic [3:0]  membyteen_q, membyteen_d;
    logic        memrwb_q, memrwb_d;
    logic        memen_q, memen_d;
    logic        wback_q, wback_d;
    logic        dack_q, dack_d;
    logic        iack_q, iack_d;
    logic [31:0] drdata_q, drdata_d;
    logic [31:0] irdata_q, irdata_d;

`ifdef MEMARB_ROUND_ROBIN_EN
    // 0: data port preferred on a d/i conflict, 1: instruction port preferred
    logic        rr_q, rr_d;
    assign prefer_i_s = rr_q;
`else
    assign prefer_i_s = 1'b0;
`endif

    // Winner selection; only consumed while in IDLE
    always_comb begin
        pick_s = SRC_NONE;
        if (wbreq) begin
            pick_s = SRC_WB;
        end else if (dreq && ireq) begin
            pick_s = prefer_i_s ? SRC_I : SRC_D;
        end else if (dreq) begin
            pick_s = SRC_D;
        end else if (ireq) begin
            pick_s = SRC_I;
        end else begin
            pick_s = SRC_NONE;
        end
    end

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        memadr_d    = memadr_q;
        memwdata_d  = memwdata_q;
        membyteen_d = membyteen_q;
        memrwb_d    = memrwb_q;
        memen_d     = memen_q;
        drdata_d    = drdata_q;
        irdata_d    = irdata_q;
        wback_d     = 1'b0;
        dack_d      = 1'b0;
        iack_d      = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                src_d = pick_s;
                case (pick_s)
                    SRC_WB: begin
                        memadr_d    = wbadr;
                        memwdata_d  = wbdata;
                        membyteen_d = wbbyteen;
                        memrwb_d    = 1'b0;
                        memen_d     = 1'b1;
                        state_d     = ST_BUSY;
                    end
                    SRC_D: begin
                        memadr_d    = dadr;
                        memwdata_d  = 32'd0;
                        membyteen_d = 4'b1111;
                        memrwb_d    = 1'b1;
                        memen_d     = 1'b1;
                        state_d     = ST_BUSY;
                    end
                    SRC_I: begin
                        memadr_d    = iadr;
                        memwdata_d  = 32'd0;
                        membyteen_d = 4'b1111;
                        memrwb_d    = 1'b1;
                        memen_d     = 1'b1;
                        state_d     = ST_BUSY;
                    end
                    default: begin
                        memen_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_BUSY: begin
                // memen is always high here, so memdone is only honoured while enabled
                if (memdone) begin
                    memen_d = 1'b0;
                    state_d = ST_ACK;
                    case (src_q)
                        SRC_WB:  wback_d = 1'b1;
                        SRC_D: begin
                            dack_d   = 1'b1;
                            drdata_d = memrdata;
                        end
                        SRC_I: begin
                            iack_d   = 1'b1;
                            irdata_d = memrdata;
                        end
                        default: state_d = ST_ACK;
                    endcase
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ACK: begin
                memen_d = 1'b0;
                state_d = ST_IDLE;
`ifdef MEMARB_ROUND_ROBIN_EN
                if (src_q == SRC_D) begin
                    rr_d = 1'b1;
                end else if (src_q == SRC_I) begin
                    rr_d = 1'b0;
                end else begin
                    rr_d = rr_q;
                end
`endif
            end
            default: begin
                memen_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_NONE;
            memadr_q    <= 30'd0;
            memwdata_q  <= 32'd0;
            membyteen_q <= 4'd0;
            memrwb_q    <= 1'b1;
            memen_q     <= 1'b0;
            wback_q     <= 1'b0;
            dack_q      <= 1'b0;
            iack_q      <= 1'b0;
            drdata_q    <= 32'd0;
            irdata_q    <= 32'd0;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            memadr_q    <= memadr_d;
            memwdata_q  <= memwdata_d;
            membyteen_q <= membyteen_d;
            memrwb_q    <= memrwb_d;
            memen_q     <= memen_d;
            wback_q     <= wback_d;
            dack_q      <= dack_d;
            iack_q      <= iack_d;
            drdata_q    <= drdata_d;
            irdata_q    <= irdata_d;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign memadr    = memadr_q;
    assign memwdata  = memwdata_q;
    assign membyteen = membyteen_q;
    assign memrwb    = memrwb_q;
    assign memen     = memen_q;
    assign wback     = wback_q;
    assign dack      = dack_q;
    assign iack      = iack_q;
    assign drdata    = drdata_q;
    assign irdata    = irdata_q;

endmodule

// File: tb/tb_memarbiter.sv
// -----------------------------------------------------------------------------
// tb_memarbiter: directed plus randomized bench for memarbiter. The bench plays
// the memory and the three requesters. Inputs are driven and outputs sampled on
// the falling clock edge. Expected winners, mem* fields, acks and read data come
// from a priority/round-robin reference model kept in bench variables.
// -----------------------------------------------------------------------------
module tb_memarbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbreq;
    logic [29:0] wbadr;
    logic [31:0] wbdata;
    logic [3:0]  wbbyteen;
    logic        wback;
    logic        dreq;
    logic [29:0] dadr;
    logic        dack;
    logic [31:0] drdata;
    logic        ireq;
    logic [29:0] iadr;
    logic        iack;
    logic [31:0] irdata;
    logic [29:0] memadr;
    logic [31:0] memwdata;
    logic [3:0]  membyteen;
    logic        memrwb;
    logic        memen;
    logic [31:0] memrdata;
    logic        memdone;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rr_i = 0;              // model: 1 -> instruction port preferred on conflict
    logic [31:0] exp_drdata = 32'd0;
    logic [31:0] exp_irdata = 32'd0;

    always #5 clk = ~clk;

    memarbiter dut (
        .clk(clk), .reset(reset),
        .wbreq(wbreq), .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen), .wback(wback),
        .dreq(dreq), .dadr(dadr), .dack(dack), .drdata(drdata),
        .ireq(ireq), .iadr(iadr), .iack(iack), .irdata(irdata),
        .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen),
        .memrwb(memrwb), .memen(memen),
        .memrdata(memrdata), .memdone(memdone)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One complete transaction, starting at a falling edge while the DUT is idle.
    // lat: memdone is sampled on the lat-th rising edge after memen rises.
    task automatic do_txn(input int lat, input bit keep, input bit drop,
                          input logic [31:0] rd, output int obs_src);
        int          exp_src;
        logic [29:0] e_adr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic        e_rwb;
        logic [2:0]  e_ack;
        obs_src = 0;
        if (wbreq)              exp_src = 1;
        else if (dreq && ireq)  exp_src = (rr_i != 0) ? 3 : 2;
        else if (dreq)          exp_src = 2;
        else if (ireq)          exp_src = 3;
        else                    exp_src = 0;
        case (exp_src)
            1: begin e_adr = wbadr; e_wd = wbdata; e_be = wbbyteen; e_rwb = 1'b0; e_ack = 3'b100; end
            2: begin e_adr = dadr;  e_wd = 32'd0;  e_be = 4'hF;     e_rwb = 1'b1; e_ack = 3'b010; end
            3: begin e_adr = iadr;  e_wd = 32'd0;  e_be = 4'hF;     e_rwb = 1'b1; e_ack = 3'b001; end
            default: begin e_adr = 30'd0; e_wd = 32'd0; e_be = 4'h0; e_rwb = 1'b1; e_ack = 3'b000; end
        endcase
        @(negedge clk);
        check("memen_rise", {31'd0, memen}, 32'd1);
        if (memen !== 1'b1) return;
        check("memadr", {2'b00, memadr}, {2'b00, e_adr});
        check("memwdata", memwdata, e_wd);
        check("membyteen", {28'd0, membyteen}, {28'd0, e_be});
        check("memrwb", {31'd0, memrwb}, {31'd0, e_rwb});
        if (drop) begin
            if (exp_src == 1) wbreq = 1'b0;
            else if (exp_src == 2) dreq = 1'b0;
            else ireq = 1'b0;
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("busy_memen", {31'd0, memen}, 32'd1);
            check("busy_memadr", {2'b00, memadr}, {2'b00, e_adr});
            check("busy_noack", {29'd0, wback, dack, iack}, 32'd0);
        end
        memrdata = rd;
        memdone  = 1'b1;
        @(negedge clk);
        memdone  = 1'b0;
        memrdata = $urandom;
        case ({wback, dack, iack})
            3'b100:  obs_src = 1;
            3'b010:  obs_src = 2;
            3'b001:  obs_src = 3;
            default: obs_src = 0;
        endcase
        if (exp_src == 2) begin
            exp_drdata = rd;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_i = 1;
`endif
        end else if (exp_src == 3) begin
            exp_irdata = rd;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_i = 0;
`endif
        end
        check("ack", {29'd0, wback, dack, iack}, {29'd0, e_ack});
        check("ack_memen", {31'd0, memen}, 32'd0);
        check("drdata", drdata, exp_drdata);
        check("irdata", irdata, exp_irdata);
        if (!keep) begin
            if (exp_src == 1) wbreq = 1'b0;
            else if (exp_src == 2) dreq = 1'b0;
            else ireq = 1'b0;
        end
        @(negedge clk);
        check("ack_one_cycle", {29'd0, wback, dack, iack}, 32'd0);
        check("memen_gap", {31'd0, memen}, 32'd0);
    endtask

    initial begin
        int o1, o2, o3;
        int seq [4];
        int r;
        reset = 1'b1; wbreq = 1'b0; dreq = 1'b0; ireq = 1'b0;
        wbadr = 30'd0; wbdata = 32'd0; wbbyteen = 4'd0; dadr = 30'd0; iadr = 30'd0;
        memrdata = 32'd0; memdone = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // reset state
        check("rst_memen", {31'd0, memen}, 32'd0);
        check("rst_memrwb", {31'd0, memrwb}, 32'd1);
        check("rst_memadr", {2'b00, memadr}, 32'd0);
        check("rst_memwdata", memwdata, 32'd0);
        check("rst_membyteen", {28'd0, membyteen}, 32'd0);
        check("rst_acks", {29'd0, wback, dack, iack}, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        check("rst_irdata", irdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // buffered write, memory answers two cycles after memen
        wbreq = 1'b1; wbadr = 30'h0AD; wbdata = 32'hDEADBEEF; wbbyteen = 4'hF;
        do_txn(2, 1'b0, 1'b0, 32'h0BADF00D, o1);
        check("wr_src", o1, 32'd1);

        // data-cache read
        dreq = 1'b1; dadr = 30'h4AD;
        do_txn(1, 1'b0, 1'b0, 32'h21212121, o1);
        check("rd_src", o1, 32'd2);
        check("rd_data", drdata, 32'h21212121);

        // all three at once: wb, then d, then i
        wbreq = 1'b1; wbadr = 30'h111; wbdata = 32'hCAFE0001; wbbyteen = 4'h5;
        dreq = 1'b1; dadr = 30'h222;
        ireq = 1'b1; iadr = 30'h333;
        do_txn(1, 1'b0, 1'b0, 32'h11111111, o1);
        do_txn(3, 1'b0, 1'b0, 32'h22222222, o2);
        do_txn(2, 1'b0, 1'b0, 32'h33333333, o3);
        check("order_0", o1, 32'd1);
        check("order_1", o2, 32'd2);
        check("order_2", o3, 32'd3);

        // d and i held for four transactions
        dreq = 1'b1; ireq = 1'b1; dadr = 30'h3A0; iadr = 30'h3B0;
        for (int t = 0; t < 4; t++) do_txn(1 + t, 1'b1, 1'b0, $urandom, seq[t]);
        dreq = 1'b0; ireq = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
        check("rr_0", seq[0], 32'd2); check("rr_1", seq[1], 32'd3);
        check("rr_2", seq[2], 32'd2); check("rr_3", seq[3], 32'd3);
`else
        check("fix_0", seq[0], 32'd2); check("fix_1", seq[1], 32'd2);
        check("fix_2", seq[2], 32'd2); check("fix_3", seq[3], 32'd2);
`endif
        @(negedge clk);

        // requester drops its request mid-transaction but is still acked
        ireq = 1'b1; iadr = 30'h1234;
        do_txn(3, 1'b0, 1'b1, 32'h5A5A5A5A, o1);
        check("drop_src", o1, 32'd3);

        // reset while busy: transaction abandoned, no ack
        dreq = 1'b1; dadr = 30'h0F0;
        @(negedge clk);
        check("pre_rst_memen", {31'd0, memen}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; dreq = 1'b0;
        exp_drdata = 32'd0; exp_irdata = 32'd0; rr_i = 0;
        check("busy_rst_memen", {31'd0, memen}, 32'd0);
        check("busy_rst_memadr", {2'b00, memadr}, 32'd0);
        check("busy_rst_memrwb", {31'd0, memrwb}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_rst_noack", {29'd0, wback, dack, iack}, 32'd0);
        end
        ireq = 1'b1; iadr = 30'h2AA;
        do_txn(2, 1'b0, 1'b0, 32'h76543210, o1);
        check("post_rst_src", o1, 32'd3);

        // stray memdone while idle is ignored
        memrdata = 32'hFFFFFFFF; memdone = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stray_memen", {31'd0, memen}, 32'd0);
            check("stray_noack", {29'd0, wback, dack, iack}, 32'd0);
            check("stray_drdata", drdata, exp_drdata);
            check("stray_irdata", irdata, exp_irdata);
        end
        memdone = 1'b0;
        @(negedge clk);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 7);
            if (r[0]) begin
                wbreq = 1'b1; wbadr = $urandom; wbdata = $urandom; wbbyteen = $urandom;
            end
            if (r[1]) begin dreq = 1'b1; dadr = $urandom; end
            if (r[2]) begin ireq = 1'b1; iadr = $urandom; end
            if (wbreq || dreq || ireq) begin
                do_txn($urandom_range(1, 4), 1'b0, ($urandom_range(0, 3) == 0), $urandom, o1);
            end else begin
                @(negedge clk);
                check("rand_idle", {31'd0, memen}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memarbiter.md
MEMARBITER -- requirements
Module: memarbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 wbreq  input  1  write-buffer request; held high until wback.
REQ-004 wbadr/wbdata/wbbyteen  input  30/32/4  write word address, data, byte enables.
REQ-005 wback  output  1  one-cycle pulse: write accepted by memory.
REQ-006 dreq/iadr-style pair: dreq  input  1, dadr  input  30  data-cache line-fill read request and address.
REQ-007 dack  output  1, drdata  output  32  one-cycle completion pulse, read data valid in same cycle.
REQ-008 ireq  input  1, iadr  input  30  instruction-cache fill read request and address.
REQ-009 iack  output  1, irdata  output  32  one-cycle completion pulse, read data valid in same cycle.
REQ-010 memadr  output  30, memwdata  output  32, membyteen  output  4, memrwb  output  1 (1=read), memen  output  1  external memory request.
REQ-011 memrdata  input  32, memdone  input  1  memory read data and completion, both sampled only while memen=1.

Function
REQ-012 FSM states IDLE, BUSY, ACK; one transaction in flight at a time.
REQ-013 IDLE: if any request high, latch winner's adr/data/byteen onto mem* outputs, memen=1, go BUSY; else stay IDLE with memen=0.
REQ-014 Fixed priority: wbreq > dreq > ireq (wb first so reads never overtake buffered writes).
REQ-015 Reads drive memrwb=1, membyteen=4'b1111, memwdata=0; writes drive memrwb=0 with wbdata/wbbyteen.
REQ-016 mem* outputs SHALL stay constant throughout BUSY.
REQ-017 BUSY: on memdone=1 capture memrdata into the winner's rdata register, drop memen, go ACK; else stay BUSY.
REQ-018 ACK: assert exactly the winner's ack for one cycle, memen=0, go IDLE.
REQ-019 Latency: request high in IDLE at edge N -> memen=1 after N; memdone sampled at edge M -> ack high for cycle after M; next memen earliest one cycle after ack (memen low >=1 cycle between transactions).
REQ-020 Requests arriving during BUSY/ACK wait; arbitration re-evaluated only in IDLE.
REQ-021 A requester that drops req mid-transaction still receives its ack; the transaction always completes.
REQ-022 memdone already high on first BUSY cycle completes the transaction that cycle (minimum 1-cycle memory).
REQ-023 drdata/irdata hold last captured value until next completion for that port; wback/dack/iack never high simultaneously.
REQ-024 memdone while memen=0 SHALL be ignored.

Reset
REQ-025 reset: state=IDLE, memen=0, memrwb=1, memadr=0, memwdata=0, membyteen=0, wback=dack=iack=0, drdata=irdata=0, round-robin pointer=data.
REQ-026 reset during BUSY abandons the transaction; no ack is issued for it.

Configuration
REQ-027 Macro MEMARB_ROUND_ROBIN_EN: when defined, dreq/ireq conflicts alternate (pointer flips to the other port after each dack/iack); wbreq remains highest priority.
REQ-028 Without MEMARB_ROUND_ROBIN_EN, fixed dreq > ireq; pointer logic absent.

Verification
REQ-029 wbreq=1, wbadr=0x0AD, wbdata=0xDEADBEEF, wbbyteen=0xF, memdone 2 cycles after memen -> memrwb=0, wback pulse 1 cycle after memdone, memen low that cycle.
REQ-030 dreq=1, dadr=0x4AD, memrdata=0x21212121 with memdone -> dack pulse, drdata=0x21212121, iack=0.
REQ-031 wbreq, dreq, ireq all high in same IDLE cycle -> service order wb, d, i; three distinct ack pulses, memen gap >=1 cycle each.
REQ-032 With MEMARB_ROUND_ROBIN_EN, dreq and ireq held high for 4 transactions -> ack order d,i,d,i; without macro -> d,d,d,d.
REQ-033 reset asserted in BUSY -> next cycle memen=0, state IDLE, no ack; fresh ireq afterwards completes normally.
REQ-034 memdone pulsed while memen=0 -> no state change, no ack.
